// File: rtl/multicycle_control_fsm_if.sv
// Control-unit port bundle: instruction fields and memory handshake in, datapath controls out.
// The master side is the control FSM; the slave side is the datapath / memory stage.
interface multicycle_control_fsm_if #(
    parameter int OP_SIZE   = 4,
    parameter int FUNC_SIZE = 6,
    parameter int CNT_W     = 16
);
    logic [OP_SIZE-1:0]   op;
    logic [FUNC_SIZE-1:0] func;
    logic                 mem_ready;
    logic                 branch_cond;
    logic                 ir_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic                 PVSWriteEn;
    logic [1:0]           pc_src;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [3:0]           ALUOp;
    logic                 carry;
    logic                 halted;
    logic                 illegal;
    logic [CNT_W-1:0]     num_inst;

    modport master (
        input  op, func, mem_ready, branch_cond,
        output ir_write, mem_read, mem_write, reg_write, PVSWriteEn, pc_src,
               ALUSrcA, ALUSrcB, ALUOp, carry, halted, illegal, num_inst
    );

    modport slave (
        output op, func, mem_ready, branch_cond,
        input  ir_write, mem_read, mem_write, reg_write, PVSWriteEn, pc_src,
               ALUSrcA, ALUSrcB, ALUOp, carry, halted, illegal, num_inst
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB control unit: decodes the latched op/func into datapath
// controls, handshakes with memory and counts retired instructions.
module multicycle_control_fsm #(
    parameter int OP_SIZE   = 4,
    parameter int FUNC_SIZE = 6,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    multicycle_control_fsm_if.master   bus
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    // store_done / branch mark cycles whose PC update is qualified by a live input.
    typedef struct packed {
        logic       fetch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       pvs;
        logic       store_done;
        logic       branch;
        logic       illegal;
        logic       halted;
        logic [1:0] pc_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [3:0] alu_op;
        logic       carry;
    } ctrl_t;

    localparam logic [OP_SIZE-1:0]   OP_BNE = OP_SIZE'(4'd0);
    localparam logic [OP_SIZE-1:0]   OP_BEQ = OP_SIZE'(4'd1);
    localparam logic [OP_SIZE-1:0]   OP_ADI = OP_SIZE'(4'd4);
    localparam logic [OP_SIZE-1:0]   OP_ORI = OP_SIZE'(4'd5);
    localparam logic [OP_SIZE-1:0]   OP_LWD = OP_SIZE'(4'd7);
    localparam logic [OP_SIZE-1:0]   OP_SWD = OP_SIZE'(4'd8);
    localparam logic [OP_SIZE-1:0]   OP_JMP = OP_SIZE'(4'd9);
    localparam logic [OP_SIZE-1:0]   OP_ALU = OP_SIZE'(4'd15);
    localparam logic [FUNC_SIZE-1:0] FN_HLT = FUNC_SIZE'(6'd29);
    localparam logic [FUNC_SIZE-1:0] FN_LIM = FUNC_SIZE'(6'd8);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b1101;
    localparam logic [3:0] ALU_OR  = 4'b1110;
    localparam logic [3:0] ALU_NOT = 4'b1100;
    localparam logic [3:0] ALU_ALS = 4'b0101;
    localparam logic [3:0] ALU_ARS = 4'b0100;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    function automatic logic is_legal(input logic [OP_SIZE-1:0] op, input logic [FUNC_SIZE-1:0] fn);
        logic ok;
        case (op)
            OP_BNE, OP_BEQ, OP_ADI, OP_ORI, OP_LWD, OP_SWD, OP_JMP: ok = 1'b1;
            OP_ALU:  ok = (fn < FN_LIM) || (fn == FN_HLT);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // {ALUOp, carry}; TCP is NOT with carry-in set.
    function automatic logic [4:0] alu_func(input logic [FUNC_SIZE-1:0] fn);
        logic [4:0] r;
        case (fn)
            FUNC_SIZE'(6'd0): r = {ALU_ADD, 1'b0};
            FUNC_SIZE'(6'd1): r = {ALU_SUB, 1'b0};
            FUNC_SIZE'(6'd2): r = {ALU_AND, 1'b0};
            FUNC_SIZE'(6'd3): r = {ALU_OR,  1'b0};
            FUNC_SIZE'(6'd4): r = {ALU_NOT, 1'b0};
            FUNC_SIZE'(6'd5): r = {ALU_NOT, 1'b1};
            FUNC_SIZE'(6'd6): r = {ALU_ALS, 1'b0};
            FUNC_SIZE'(6'd7): r = {ALU_ARS, 1'b0};
            default:          r = {ALU_ADD, 1'b0};
        endcase
        return r;
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t st, input logic [OP_SIZE-1:0] op,
                                          input logic [FUNC_SIZE-1:0] fn);
        ctrl_t      c;
        logic [4:0] alu_c;
        c     = '0;
        alu_c = alu_func(fn);
        case (st)
            S_IF: begin
                c.fetch    = 1'b1;
                c.mem_read = 1'b1;
                c.src_b    = 2'd1;
                c.alu_op   = ALU_ADD;
            end
            S_ID: begin
                if (!is_legal(op, fn)) begin
                    c.illegal = 1'b1;
                    c.pvs     = 1'b1;
                end else if (op == OP_JMP) begin
                    c.pc_src = 2'd2;
                    c.pvs    = 1'b1;
                end else begin
                    c.pvs = 1'b0;
                end
            end
            S_EX: begin
                c.src_a = 2'd1;
                case (op)
                    OP_ALU: begin
                        c.src_b  = 2'd0;
                        c.alu_op = alu_c[4:1];
                        c.carry  = alu_c[0];
                    end
                    OP_ADI, OP_LWD, OP_SWD: begin
                        c.src_b  = 2'd2;
                        c.alu_op = ALU_ADD;
                    end
                    OP_ORI: begin
                        c.src_b  = 2'd3;
                        c.alu_op = ALU_OR;
                    end
                    OP_BNE, OP_BEQ: begin
                        c.alu_op = ALU_SUB;
                        c.pvs    = 1'b1;
                        c.branch = 1'b1;
                    end
                    default: c.src_a = 2'd0;
                endcase
            end
            S_MEM: begin
                c.mem_read   = (op == OP_LWD);
                c.mem_write  = (op == OP_SWD);
                c.store_done = (op == OP_SWD);
            end
            S_WB: begin
                c.reg_write = 1'b1;
                c.pvs       = 1'b1;
            end
            S_HALT:  c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t               state_r;
    state_t               next_state_s;
    logic [OP_SIZE-1:0]   op_r;
    logic [OP_SIZE-1:0]   next_op_s;
    logic [FUNC_SIZE-1:0] func_r;
    logic [FUNC_SIZE-1:0] next_func_s;
    ctrl_t                ctrl_r;
    logic [CNT_W-1:0]     num_inst_r;
    logic                 pvs_s;

    // Next state and instruction latch; op/func are only captured on the fetch handshake.
    always_comb begin
        next_state_s = state_r;
        next_op_s    = op_r;
        next_func_s  = func_r;
        case (state_r)
            S_IF: begin
                if (bus.mem_ready) begin
                    next_state_s = S_ID;
                    next_op_s    = bus.op;
                    next_func_s  = bus.func;
                end else begin
                    next_state_s = S_IF;
                end
            end
            S_ID: begin
                if (!is_legal(op_r, func_r) || (op_r == OP_JMP)) begin
                    next_state_s = S_IF;
                end else if ((op_r == OP_ALU) && (func_r == FN_HLT)) begin
                    next_state_s = S_HALT;
                end else begin
                    next_state_s = S_EX;
                end
            end
            S_EX: begin
                if ((op_r == OP_BNE) || (op_r == OP_BEQ)) begin
                    next_state_s = S_IF;
                end else if ((op_r == OP_LWD) || (op_r == OP_SWD)) begin
                    next_state_s = S_MEM;
                end else begin
                    next_state_s = S_WB;
                end
            end
            S_MEM: begin
                if (!bus.mem_ready) begin
                    next_state_s = S_MEM;
                end else if (op_r == OP_LWD) begin
                    next_state_s = S_WB;
                end else begin
                    next_state_s = S_IF;
                end
            end
            S_WB:    next_state_s = S_IF;
            S_HALT:  next_state_s = S_HALT;
            default: next_state_s = S_IF;
        endcase
    end

    // Controls are registered for the state being entered so outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IF;
            op_r       <= {OP_SIZE{1'b0}};
            func_r     <= {FUNC_SIZE{1'b0}};
            ctrl_r     <= decode_ctrl(S_IF, {OP_SIZE{1'b0}}, {FUNC_SIZE{1'b0}});
            num_inst_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            op_r    <= next_op_s;
            func_r  <= next_func_s;
            ctrl_r  <= decode_ctrl(next_state_s, next_op_s, next_func_s);
            if (pvs_s) begin
                num_inst_r <= num_inst_r + CNT_ONE;
            end else begin
                num_inst_r <= num_inst_r;
            end
        end
    end

    assign pvs_s = ctrl_r.pvs | (ctrl_r.store_done & bus.mem_ready);

    assign bus.ir_write   = ctrl_r.fetch & bus.mem_ready;
    assign bus.mem_read   = ctrl_r.mem_read;
    assign bus.mem_write  = ctrl_r.mem_write;
    assign bus.reg_write  = ctrl_r.reg_write;
    assign bus.PVSWriteEn = pvs_s;
    assign bus.pc_src     = ctrl_r.pc_src | {1'b0, ctrl_r.branch & bus.branch_cond};
    assign bus.ALUSrcA    = ctrl_r.src_a;
    assign bus.ALUSrcB    = ctrl_r.src_b;
    assign bus.ALUOp      = ctrl_r.alu_op;
    assign bus.carry      = ctrl_r.carry;
    assign bus.halted     = ctrl_r.halted;
    assign bus.illegal    = ctrl_r.illegal;
    assign bus.num_inst   = num_inst_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed + randomized bench: each instruction is expanded into its expected per-cycle
// control timeline from the instruction class, and every cycle is compared against the DUT.
module tb_multicycle_control_fsm;
    localparam int OP_SIZE   = 4;
    localparam int FUNC_SIZE = 6;
    localparam int CNT_W     = 4;

    // Enable vector layout: {ir_write, mem_read, mem_write, reg_write, PVSWriteEn, illegal, halted}
    localparam logic [6:0] E_IR = 7'b1000000;
    localparam logic [6:0] E_MR = 7'b0100000;
    localparam logic [6:0] E_MW = 7'b0010000;
    localparam logic [6:0] E_RW = 7'b0001000;
    localparam logic [6:0] E_PV = 7'b0000100;
    localparam logic [6:0] E_IL = 7'b0000010;
    localparam logic [6:0] E_HA = 7'b0000001;
    localparam logic [8:0] IF_ALU = {2'd0, 2'd1, 4'b0000, 1'b0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   model_cnt = 0;

    // {ALUOp, carry} expected for R-type func 0..7
    logic [4:0] rtab [8] = '{5'b00000, 5'b00010, 5'b11010, 5'b11100,
                             5'b11000, 5'b11001, 5'b01010, 5'b01000};
    logic [3:0] ops [10] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd15, 4'd15, 4'd15};

    multicycle_control_fsm_if #(.OP_SIZE(OP_SIZE), .FUNC_SIZE(FUNC_SIZE), .CNT_W(CNT_W)) bus ();

    multicycle_control_fsm #(.OP_SIZE(OP_SIZE), .FUNC_SIZE(FUNC_SIZE), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom);
    endfunction

    function automatic logic [5:0] rfn();
        return 6'($urandom);
    endfunction

    function automatic bit legal(input logic [3:0] op, input logic [5:0] fn);
        if (op == 4'd15) return (fn < 6'd8) || (fn == 6'd29);
        return op inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input string tag, input logic rdy, input logic bc,
                         input logic [3:0] op_d, input logic [5:0] fn_d,
                         input logic [6:0] exp_en, input logic [1:0] exp_pc,
                         input logic [8:0] alu_mask, input logic [8:0] exp_alu);
        logic [6:0] en;
        logic [8:0] alu;
        @(negedge clk);
        bus.mem_ready   = rdy;
        bus.branch_cond = bc;
        bus.op          = op_d;
        bus.func        = fn_d;
        #1;
        en  = {bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write,
               bus.PVSWriteEn, bus.illegal, bus.halted};
        alu = {bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.carry};
        chk({tag, ".en"}, 16'(en), 16'(exp_en));
        chk({tag, ".pc_src"}, 16'(bus.pc_src), 16'(exp_pc));
        if (alu_mask != 9'd0) chk({tag, ".alu"}, 16'(alu & alu_mask), 16'(exp_alu & alu_mask));
        chk({tag, ".num_inst"}, 16'(bus.num_inst), 16'(model_cnt % (1 << CNT_W)));
        if ((exp_en & E_PV) != 7'd0) model_cnt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        bus.mem_ready = 1'b0;
        bus.op        = rop();
        bus.func      = rfn();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        model_cnt = 0;
        cycle("RST", 1'b0, rb(), rop(), rfn(), E_MR, 2'd0, 9'h1FF, IF_ALU);
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [5:0] fn, input logic bc,
                             input int if_waits, input int mem_waits, input int reset_at);
        logic       rdy;
        logic [8:0] ex_alu;
        logic [8:0] ex_mask;
        for (int k = 0; k <= if_waits; k++) begin
            rdy = (k == if_waits);
            cycle("IF", rdy, rb(), rdy ? op : rop(), rdy ? fn : rfn(),
                  E_MR | (rdy ? E_IR : 7'd0), 2'd0, 9'h1FF, IF_ALU);
        end
        if (!legal(op, fn)) begin
            cycle("ID.illegal", rb(), rb(), rop(), rfn(), E_PV | E_IL, 2'd0, 9'd0, 9'd0);
            return;
        end
        if (op == 4'd9) begin
            cycle("ID.jmp", rb(), rb(), rop(), rfn(), E_PV, 2'd2, 9'd0, 9'd0);
            return;
        end
        if ((op == 4'd15) && (fn == 6'd29)) begin
            cycle("ID.hlt", rb(), rb(), rop(), rfn(), 7'd0, 2'd0, 9'd0, 9'd0);
            for (int k = 0; k < 20; k++) begin
                cycle("HALT", rb(), rb(), rop(), rfn(), E_HA, 2'd0, 9'd0, 9'd0);
            end
            return;
        end
        cycle("ID", rb(), rb(), rop(), rfn(), 7'd0, 2'd0, 9'd0, 9'd0);
        if ((op == 4'd0) || (op == 4'd1)) begin
            cycle("EX.branch", rb(), bc, rop(), rfn(), E_PV, {1'b0, bc},
                  9'b000011110, {4'd0, 4'b0001, 1'b0});
            return;
        end
        case (op)
            4'd15:   begin ex_mask = 9'h1FF; ex_alu = {2'd1, 2'd0, rtab[fn[2:0]]}; end
            4'd5:    begin ex_mask = 9'h07F; ex_alu = {2'd1, 2'd3, 4'b1110, 1'b0}; end
            default: begin ex_mask = 9'h07F; ex_alu = {2'd1, 2'd2, 4'b0000, 1'b0}; end
        endcase
        cycle("EX", rb(), rb(), rop(), rfn(), 7'd0, 2'd0, ex_mask, ex_alu);
        if ((op == 4'd7) || (op == 4'd8)) begin
            for (int k = 0; k <= mem_waits; k++) begin
                rdy = (k == mem_waits);
                if (k == reset_at) begin
                    do_reset();
                    return;
                end
                if (op == 4'd7) begin
                    cycle("MEM.lwd", rdy, rb(), rop(), rfn(), E_MR, 2'd0, 9'd0, 9'd0);
                end else begin
                    cycle("MEM.swd", rdy, rb(), rop(), rfn(), E_MW | (rdy ? E_PV : 7'd0),
                          2'd0, 9'd0, 9'd0);
                end
            end
            if (op == 4'd8) return;
        end
        cycle("WB", rb(), rb(), rop(), rfn(), E_RW | E_PV, 2'd0, 9'd0, 9'd0);
    endtask

    initial begin
        logic [3:0] op;
        logic [5:0] fn;
        bus.mem_ready   = 1'b0;
        bus.branch_cond = 1'b0;
        bus.op          = 4'd0;
        bus.func        = 6'd0;
        do_reset();

        run_instr(4'd7, rfn(), 1'b0, 0, 3, 1);
        run_instr(4'd15, 6'd5, 1'b0, 0, 0, -1);
        run_instr(4'd7, rfn(), 1'b0, 0, 3, -1);
        run_instr(4'd1, rfn(), 1'b1, 0, 0, -1);
        run_instr(4'd0, rfn(), 1'b0, 2, 0, -1);
        run_instr(4'd12, rfn(), 1'b0, 0, 0, -1);
        run_instr(4'd15, 6'd40, 1'b0, 1, 0, -1);
        run_instr(4'd9, rfn(), 1'b0, 0, 0, -1);
        run_instr(4'd5, rfn(), 1'b1, 0, 0, -1);
        run_instr(4'd8, rfn(), 1'b0, 0, 2, -1);
        for (int f = 0; f < 8; f++) run_instr(4'd15, 6'(f), rb(), 0, 0, -1);
        run_instr(4'd15, 6'd29, 1'b0, 0, 0, -1);
        do_reset();

        for (int i = 0; i < 16; i++) run_instr(4'd4, rfn(), rb(), 0, 0, -1);
        cycle("WRAP", 1'b0, 1'b0, rop(), rfn(), E_MR, 2'd0, 9'h1FF, IF_ALU);
        chk("wrap.zero", 16'(bus.num_inst), 16'd0);

        for (int i = 0; i < 300; i++) begin
            op = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) op = rop();
            fn = rfn();
            if ((op == 4'd15) && ($urandom_range(0, 7) != 0)) fn = 6'($urandom_range(0, 7));
            run_instr(op, fn, rb(), $urandom_range(0, 3), $urandom_range(0, 3), -1);
            if ((op == 4'd15) && (fn == 6'd29)) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
